fifo_wr_ptr_ctrl: RTL and testbench
===================================

// Module: fifo_wr_ptr_ctrl
// PURPOSE
//   Write-side control for the dual-clock asynchronous FIFO, in the source domain (clk_s).
//   Generates the binary write_pointer and write strobe for the 8x8 FIFO memory.
//   Exports a Gray-coded write pointer to the read domain.
//   Synchronizes the read domain's Gray pointer and derives full / almost_full / fill level / overflow.
// PARAMETERS
//   ADDR_W       3    memory address width; DEPTH = 2**ADDR_W = 8
//   SYNC_STAGES  2    flop stages on incoming read Gray pointer (min 2)
//   AF_THRESH    6    almost_full asserted when level >= AF_THRESH (1..DEPTH)
// PORTS
//   clk_s          in   1         source-domain clock
//   rst            in   1         synchronous, active-high reset
//   wr_en          in   1         producer write request, data presented to memory din same cycle
//   rd_gray_async  in   ADDR_W+1  read pointer, Gray, from clk_d domain (asynchronous)
//   write_pointer  out  ADDR_W    binary write address to FIFO memory
//   mem_we         out  1         memory write enable; memory write port qualified by this
//   wr_gray        out  ADDR_W+1  registered Gray write pointer, to read-domain synchronizer
//   full           out  1         FIFO full, registered
//   almost_full    out  1         level >= AF_THRESH, registered
//   wr_level       out  ADDR_W+1  fill level seen from write side, 0..DEPTH, registered
//   overflow       out  1         sticky: a write was attempted while full
// BEHAVIOUR
//   - Internal wbin [ADDR_W:0]: extra MSB is the wrap bit.
//     write_pointer = wbin[ADDR_W-1:0].
//     wr_gray = reg(wbin_next ^ (wbin_next>>1)).
//   - Accept = wr_en & ~full. mem_we = accept (combinational, same cycle).
//   - On accept, wbin increments by 1 at next clk_s edge, mod 2**(ADDR_W+1). No other updates.
//   - Sync chain: rd_gray_async passes through SYNC_STAGES flops to give rq_gray. No logic between stages.
//   - full <= (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}).
//     - Registered.
//     - Asserts on the edge that accepts the DEPTH-th outstanding write.
//   - rq_bin = gray2bin(rq_gray).
//     wr_level <= (wbin_next - rq_bin) mod 2**(ADDR_W+1).
//     almost_full <= (that value >= AF_THRESH).
//   - overflow <= 1 when wr_en & full. Held until rst.
//   - Read-side frees become visible SYNC_STAGES+1 cycles after rd_gray_async changes.
//     full deasserts pessimistically, never early.
//   - Write when full: rejected, mem_we=0, pointers unchanged, overflow set.
//   - Wrap: write_pointer 7->0 while the wbin MSB toggles. Gray changes exactly 1 bit per increment.
//   - Reset (any time, incl. mid-burst): wbin, wr_gray, all sync flops, full, almost_full,
//     wr_level, overflow -> 0. mem_we = 0 while rst=1.
//     Read domain must be reset concurrently.
// TESTING
//   1 rst=1 for 2 cycles, then release -> write_pointer=0, wr_gray=0000, full=0, wr_level=0, overflow=0.
//   2 rd_gray_async=0000, wr_en=1 for 8 cycles -> write_pointer 0..7, mem_we=1 each cycle;
//     after 8th edge: full=1, wr_gray=1100, wr_level=8; almost_full=1 after 6th edge.
//   3 From full, wr_en=1 one more cycle -> mem_we=0, write_pointer stays 0, overflow=1 and stays 1.
//   4 From full, set rd_gray_async=0010 (rptr=3) -> full=0 and wr_level=5 exactly 3 cycles later (SYNC_STAGES=2).
//   5 16 accepted writes, reads tracking -> wr_gray sequence single-bit steps;
//     wraps 1000->0000; full never falsely set.
//   6 rst=1 asserted after 5 writes -> all outputs 0 next edge; following write lands at write_pointer=0.

Source files
------------

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer control for a dual-clock FIFO (source domain clk_s).
// Produces the binary write address and strobe, exports a Gray write pointer, and derives full/level/overflow.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic              clk_s,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_gray_async,
    output logic [ADDR_W-1:0] write_pointer,
    output logic              mem_we,
    output logic [ADDR_W:0]   wr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    logic [ADDR_W:0] r_wbin;
    logic [ADDR_W:0] r_wr_gray;
    logic [ADDR_W:0] r_level;
    logic            r_full;
    logic            r_af;
    logic            r_ovf;
    logic [ADDR_W:0] r_sync [SYNC_STAGES];

    logic            w_accept;
    logic [ADDR_W:0] w_wbin_next;
    logic [ADDR_W:0] w_wgray_next;
    logic [ADDR_W:0] w_rq_gray;
    logic [ADDR_W:0] w_rq_bin;
    logic [ADDR_W:0] w_full_gray;
    logic [ADDR_W:0] w_level_next;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A write is never accepted while reset is held, even if the full flag is stale.
    assign w_accept     = wr_en & ~r_full & ~rst;
    assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    assign w_rq_gray    = r_sync[SYNC_STAGES-1];
    assign w_rq_bin     = gray2bin(w_rq_gray);
    assign w_full_gray  = {~w_rq_gray[ADDR_W:ADDR_W-1], w_rq_gray[ADDR_W-2:0]};
    assign w_level_next = w_wbin_next - w_rq_bin;

    always_ff @(posedge clk_s) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= rd_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk_s) begin
        if (rst) begin
            r_wbin    <= '0;
            r_wr_gray <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_af      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wbin    <= w_wbin_next;
            r_wr_gray <= w_wgray_next;
            r_level   <= w_level_next;
            r_full    <= (w_wgray_next == w_full_gray);
            r_af      <= (w_level_next >= (ADDR_W+1)'(AF_THRESH));
            r_ovf     <= r_ovf | (wr_en & r_full);
        end
    end

    assign write_pointer = r_wbin[ADDR_W-1:0];
    assign mem_we        = w_accept;
    assign wr_gray       = r_wr_gray;
    assign full          = r_full;
    assign almost_full   = r_af;
    assign wr_level      = r_level;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl: directed scenarios plus randomized traffic, compared against
// a pointer-count model of the FIFO occupancy every cycle.
module tb_fifo_wr_ptr_ctrl;

    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 8;
    localparam int AFT    = 6;

    logic clk_s = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    int   rd_bin = 0;
    logic [ADDR_W:0] rd_gray_async;
    logic [ADDR_W-1:0] write_pointer;
    logic mem_we, full, almost_full, overflow;
    logic [ADDR_W:0] wr_gray, wr_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    assign rd_gray_async = 4'(rd_bin ^ (rd_bin >> 1));

    always #5 clk_s = ~clk_s;

    fifo_wr_ptr_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AF_THRESH(AFT)) dut (
        .clk_s(clk_s), .rst(rst), .wr_en(wr_en), .rd_gray_async(rd_gray_async),
        .write_pointer(write_pointer), .mem_we(mem_we), .wr_gray(wr_gray),
        .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    // Model: count of writes (mod 16), delayed view of the read count, occupancy derived by subtraction.
    int m_wcnt = 0, m_level = 0, m_gray = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;
    int m_sync [SYNC];

    initial for (int i = 0; i < SYNC; i++) m_sync[i] = 0;

    always @(posedge clk_s) begin : model
        int nw, lvl;
        if (rst) begin
            m_wcnt <= 0; m_level <= 0; m_gray <= 0;
            m_full <= 0; m_af <= 0; m_ovf <= 0;
            for (int i = 0; i < SYNC; i++) m_sync[i] <= 0;
        end else begin
            nw  = (wr_en && !m_full) ? (m_wcnt + 1) % 16 : m_wcnt;
            lvl = (nw - m_sync[SYNC-1] + 16) % 16;
            m_wcnt  <= nw;
            m_gray  <= nw ^ (nw >> 1);
            m_level <= lvl;
            m_full  <= (lvl == DEPTH);
            m_af    <= (lvl >= AFT);
            m_ovf   <= m_ovf | (wr_en && m_full);
            m_sync[0] <= rd_bin;
            for (int i = 1; i < SYNC; i++) m_sync[i] <= m_sync[i-1];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_s) begin
        if (chk_en) begin
            chk("wp",       int'(write_pointer), m_wcnt % DEPTH);
            chk("mem_we",   int'(mem_we),        int'(wr_en && !m_full && !rst));
            chk("wr_gray",  int'(wr_gray),       m_gray);
            chk("full",     int'(full),          int'(m_full));
            chk("af",       int'(almost_full),   int'(m_af));
            chk("level",    int'(wr_level),      m_level);
            chk("overflow", int'(overflow),      int'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    function automatic bit rd_pending();
        return ((m_wcnt - rd_bin + 16) % 16) != 0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt, prev, cur;
        bit wrap_seen;

        // Reset for two edges, then release.
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_s);
        chk("t1_wp", int'(write_pointer), 0);
        chk("t1_gray", int'(wr_gray), 0);
        chk("t1_full", int'(full), 0);
        chk("t1_level", int'(wr_level), 0);
        chk("t1_ovf", int'(overflow), 0);
        step();

        // Fill with read pointer parked at 0.
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_s);
            chk("t2_wp", int'(write_pointer), i);
            chk("t2_we", int'(mem_we), 1);
            chk("t2_af", int'(almost_full), int'(i >= AFT));
            step();
        end
        @(negedge clk_s);
        chk("t2_full", int'(full), 1);
        chk("t2_gray", int'(wr_gray), 4'b1100);
        chk("t2_level", int'(wr_level), 8);
        chk("t3_we", int'(mem_we), 0);
        step();

        // Rejected write while full.
        wr_en = 1'b0;
        @(negedge clk_s);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_wp", int'(write_pointer), 0);
        chk("t3_full", int'(full), 1);

        // Read side frees three entries; visible on the third edge.
        rd_bin = 3;
        step();
        @(negedge clk_s); chk("t4_full_e1", int'(full), 1);
        step();
        @(negedge clk_s); chk("t4_full_e2", int'(full), 1);
        step();
        @(negedge clk_s);
        chk("t4_full_e3", int'(full), 0);
        chk("t4_level_e3", int'(wr_level), 5);
        chk("t4_ovf", int'(overflow), 1);
        step();

        // Sixteen accepted writes with reads tracking; Gray steps and wrap.
        acc_cnt = 0; wrap_seen = 0; prev = int'(wr_gray);
        for (int cyc = 0; cyc < 80 && acc_cnt < 16; cyc++) begin
            wr_en = 1'b1;
            if (rd_pending()) rd_bin = (rd_bin + 1) % 16;
            @(negedge clk_s);
            if (!m_full) acc_cnt++;
            cur = int'(wr_gray);
            if (cur != prev) chk("t5_gray_step", $countones(cur ^ prev), 1);
            if (prev == 8 && cur == 0) wrap_seen = 1;
            prev = cur;
            step();
        end
        wr_en = 1'b0;
        @(negedge clk_s);
        cur = int'(wr_gray);
        if (cur != prev) chk("t5_gray_step", $countones(cur ^ prev), 1);
        if (prev == 8 && cur == 0) wrap_seen = 1;
        chk("t5_accepts", acc_cnt, 16);
        chk("t5_wrap", int'(wrap_seen), 1);
        step();

        // Reset in the middle of a burst.
        rst = 1'b1; rd_bin = 0;
        step();
        rst = 1'b0; wr_en = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk_s);
        chk("t6_we_rst", int'(mem_we), 0);
        step();
        @(negedge clk_s);
        chk("t6_wp", int'(write_pointer), 0);
        chk("t6_gray", int'(wr_gray), 0);
        chk("t6_level", int'(wr_level), 0);
        chk("t6_ovf", int'(overflow), 0);
        rst = 1'b0;
        #1;
        chk("t6_we", int'(mem_we), 1);
        step();
        @(negedge clk_s);
        chk("t6_wp_next", int'(write_pointer), 1);
        step();

        // Random traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst   = ($urandom_range(0, 199) == 0);
            wr_en = ($urandom_range(0, 3) != 0);
            if (rst) rd_bin = 0;
            else if (rd_pending() && $urandom_range(0, 1) == 1) rd_bin = (rd_bin + 1) % 16;
            step();
        end
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk_s);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
